// File: rtl/tff_cell.sv
// Single-bit toggle storage cell: each synchronized rising edge of we flips the
// stored bit; re gates the stored bit onto a registered output.
module tff_cell #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic we,
    input  logic re,
    output logic out
);

    logic we_s;
    logic re_s;
    logic we_hist;
    logic state;
    logic toggle;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign we_s = we;
            assign re_s = re;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] we_sync;
            logic [SYNC_STAGES-1:0] re_sync;

            // Strobes arrive from array control that may be asynchronous to clk.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    we_sync <= '0;
                    re_sync <= '0;
                end else begin
                    we_sync[0] <= we;
                    re_sync[0] <= re;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        we_sync[i] <= we_sync[i-1];
                        re_sync[i] <= re_sync[i-1];
                    end
                end
            end

            assign we_s = we_sync[SYNC_STAGES-1];
            assign re_s = re_sync[SYNC_STAGES-1];
        end
    endgenerate

    // we_hist resets low, so we held high across reset release counts as an edge.
    assign toggle = we_s & ~we_hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_hist <= 1'b0;
            state   <= RESET_VALUE;
            out     <= 1'b0;
        end else begin
            we_hist <= we_s;
            if (toggle) begin
                state <= ~state;
            end
            out <= re_s ? state : 1'b0;
        end
    end

endmodule

// File: tb/tb_tff_cell.sv
// Directed self-checking bench for tff_cell with two synchronizer stages.
module tb_tff_cell;

    logic clk;
    logic rst;
    logic we;
    logic re;
    logic out;

    int checkCount;
    int passCount;

    tff_cell #(
        .SYNC_STAGES(2),
        .RESET_VALUE(1'b0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .we (we),
        .re (re),
        .out(out)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic weVal, input logic reVal);
        we = weVal;
        re = reVal;
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: out=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checkCount = 0;
        passCount = 0;
        applyStimulus(1'b0, 1'b0);

        // Reset and read of the reset value
        step(2);
        checkOutput("reset_out", out, 1'b0);
        rst = 1'b0;
        step(1);
        checkOutput("post_reset_out", out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        step(2);
        checkOutput("read_latency", out, 1'b0);
        step(1);
        checkOutput("read_reset_value", out, 1'b0);
        applyStimulus(1'b0, 1'b0);
        step(4);

        // Single 2-cycle toggle pulse, then read with latency check
        applyStimulus(1'b1, 1'b0);
        step(2);
        applyStimulus(1'b0, 1'b0);
        step(4);
        applyStimulus(1'b0, 1'b1);
        step(2);
        checkOutput("single_read_lat", out, 1'b0);
        step(1);
        checkOutput("single_toggle", out, 1'b1);

        // Exact toggle timing with re already high, then held-high we
        applyStimulus(1'b1, 1'b1);
        step(3);
        checkOutput("toggle_timing_pre", out, 1'b1);
        step(1);
        checkOutput("toggle_timing", out, 1'b0);
        step(8);
        checkOutput("held_high_once", out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        step(4);
        checkOutput("held_high_release", out, 1'b0);

        // Double and triple toggles
        applyStimulus(1'b1, 1'b1);
        step(2);
        applyStimulus(1'b0, 1'b1);
        step(4);
        checkOutput("double_first", out, 1'b1);
        applyStimulus(1'b1, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1);
        step(5);
        checkOutput("double_second", out, 1'b0);
        applyStimulus(1'b1, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1);
        step(5);
        checkOutput("triple", out, 1'b1);

        // Read gating, state stays 1
        applyStimulus(1'b0, 1'b0);
        step(2);
        checkOutput("gate_lat", out, 1'b1);
        step(1);
        checkOutput("gate_off", out, 1'b0);
        step(3);
        checkOutput("gate_low", out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        step(3);
        checkOutput("gate_reread1", out, 1'b1);
        applyStimulus(1'b0, 1'b0);
        step(3);
        checkOutput("gate_off2", out, 1'b0);
        applyStimulus(1'b0, 1'b1);
        step(3);
        checkOutput("gate_reread2", out, 1'b1);

        // Collision: toggle and read reach the cell on the same edge
        applyStimulus(1'b0, 1'b0);
        step(4);
        applyStimulus(1'b1, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1);
        step(2);
        checkOutput("collide_old", out, 1'b1);
        step(1);
        checkOutput("collide_new", out, 1'b0);

        // Back to state 1 for the reset tests
        applyStimulus(1'b1, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1);
        step(5);
        checkOutput("pre_reset_read", out, 1'b1);

        // Async reset mid-read with a toggle still in the synchronizer
        applyStimulus(1'b1, 1'b1);
        step(1);
        applyStimulus(1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("reset_async", out, 1'b0);
        step(2);
        rst = 1'b0;
        step(5);
        checkOutput("reset_discard", out, 1'b0);

        // we held high across reset release counts as one edge
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1);
        step(2);
        rst = 1'b0;
        step(2);
        applyStimulus(1'b0, 1'b1);
        step(3);
        checkOutput("we_across_reset", out, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tff_cell.md
Name: tff_cell

Overview:
- Single-bit toggle storage cell. Each rising edge of the write strobe flips the stored bit. A read strobe gates the stored bit onto a registered output.
- Sits as the leaf storage element of the toggle-memory array. WE/RE come from array control logic that may be asynchronous to the local clock, so both strobes are synchronized inside the cell.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each of we and re; legal range 0..4; 0 means the inputs are used directly.
- RESET_VALUE, 1'b0, value loaded into the stored bit by reset.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write/toggle strobe; a rising edge requests one toggle; level-sensitive width ignored.
- re  input  1  read enable; while high (after sync) the stored bit is driven to out.
- out  output  1  registered read data; 0 when not reading.

Behaviour:
- Internal registers: we_sync[SYNC_STAGES], re_sync[SYNC_STAGES], we_hist, state, out.
- Reset (rst high, asynchronous, immediate, independent of clk):
  - state = RESET_VALUE; out = 0.
  - All synchronizer flops = 0; we_hist = 0.
  - Everything holds while rst is high.
- Synchronizers:
  - we_s is the last flop of the we chain; re_s is the last flop of the re chain.
  - With SYNC_STAGES = 0, we_s = we and re_s = re.
- Edge detect:
  - we_hist <= we_s every clock.
  - Toggle condition: we_s & ~we_hist.
- Toggle timing and rules:
  - If edge k is the first clock edge sampling we high, state flips at edge k+SYNC_STAGES.
  - Exactly one toggle per we rising edge, regardless of pulse width.
  - we must stay low at least SYNC_STAGES+1 cycles between pulses for each pulse to be counted; closer pulses may merge into one toggle.
  - we high across reset release counts as a rising edge: one toggle, because we_hist resets to 0.
- Read:
  - out <= re_s ? state : 0 every clock.
  - out reflects state one clock after re_s is high.
  - Reads are non-destructive: state is unchanged by re.
- Simultaneous toggle and read on the same edge: out takes the pre-toggle state; the new value appears on the next edge if re_s is still high.
- re low: out returns to 0 one clock after re_s falls.
- Reset mid-operation: state, out and all pipelines clear immediately; pending toggles in the synchronizers are discarded.
- No combinational path from any input to out.

Test Plan:
- Reset: pulse rst high for 1 cycle with we=re=0 -> out=0; with re=1 afterwards out=RESET_VALUE (0) after SYNC_STAGES+1 cycles.
- Single toggle: one we pulse 2 cycles wide, then re=1 -> out=1 at cycle SYNC_STAGES+1 after re rises; held-high we gives only one toggle.
- Double toggle: two separated we pulses (2 cycles, 1 cycle wide, gap >= SYNC_STAGES+1), then re=1 -> out=0; three pulses -> out=1.
- Read gating: state=1, toggle re 1->0 -> out follows with 1 cycle of latency after sync; out=0 while re low; state stays 1 after several reads.
- Reset mid-read: state=1, re=1, out=1, assert rst asynchronously between clock edges -> out=0 immediately; after release with re=1, out=0.
- Collision: we edge and re_s aligned on the same clock edge -> out shows the old value for 1 cycle, then the toggled value.
